rf_read_arbiter: RTL and testbench
==================================

Name: rf_read_arbiter

Overview:
- Shares the register file's single read channel (rs1/rs2 flags, 5-bit indices, index tag, 1-cycle registered return) among NUM_REQ requesters, such as the reservation station and the load/store buffer.
- Accepts one request at a time under round-robin arbitration, sequences it through the register file, and returns both operands to the winner.
- Optionally patches stale data with ROB commits that race the read.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
TAG_WIDTH, 2, width of the request tag passed to and from the register file index

Ports:
clk_in  input  1  clock
rst_n_in  input  1  reset; asynchronous, active-low
rdy_in  input  1  global ready; low freezes all state and outputs
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  one-hot grant; handshake on valid&ready
req_rs1_en  input  NUM_REQ  operand 1 wanted
req_rs2_en  input  NUM_REQ  operand 2 wanted
req_rs1  input  NUM_REQ*5  operand 1 register, requester k at [5k+4:5k]
req_rs2  input  NUM_REQ*5  operand 2 register
req_tag  input  NUM_REQ*TAG_WIDTH  requester tag
to_rf_rs1_flag  output  1  read operand 1
to_rf_rs2_flag  output  1  read operand 2
to_rf_rs1  output  5  operand 1 register
to_rf_rs2  output  5  operand 2 register
to_rf_index  output  TAG_WIDTH  tag sent to register file
from_rf_rs1_flag  input  1  operand 1 data valid
from_rf_rs2_flag  input  1  operand 2 data valid
from_rf_index  input  TAG_WIDTH  returned tag
from_rf_rs1  input  32  operand 1 data
from_rf_rs2  input  32  operand 2 data
from_rob  input  1  ROB commit this cycle
from_rob_rd  input  5  commit destination
from_rob_wdata  input  32  commit data
resp_valid  output  NUM_REQ  one-hot, one-cycle response pulse to the granted requester
resp_tag  output  TAG_WIDTH  tag of the response
resp_rs1  output  32  operand 1 value (0 if not requested)
resp_rs2  output  32  operand 2 value (0 if not requested)

Behaviour:
- Reset (rst_n_in low, async): state IDLE, rr pointer 0, all outputs 0, captured operands 0. A reset mid-operation abandons the transaction; any late from_rf_* data is ignored because the block is in IDLE.
- rdy_in low: no state, pointer or register changes; req_ready forced 0; registered outputs hold.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: req_ready is combinational. It selects the first valid requester scanning from the rr pointer upward with wrap, and is asserted only in IDLE with rdy_in high. On handshake, the block captures rs1/rs2/enables/tag and the pointer becomes grant+1 (mod NUM_REQ).
  - Grant with any enable set: go to ISSUE. Grant with no enable set: go to RESP with both operands 0 and no register-file traffic.
  - ISSUE, exactly one cycle: to_rf_rs1_flag/to_rf_rs2_flag equal the captured enables, and indices and tag are driven. Then go to WAIT. Flags are low in every other state.
  - WAIT: each operand is latched when its from_rf flag is high and from_rf_index equals the captured tag. Leave for RESP once every enabled operand is latched (normally the next cycle). Mismatched or unexpected returns are ignored.
  - RESP, exactly one cycle: the resp_valid bit of the granted requester is high; resp_tag, resp_rs1 and resp_rs2 hold the captured values. Then go to IDLE.
- Latency: handshake edge N; ISSUE is cycle N+1; WAIT is cycle N+2; resp_valid is high in cycle N+3. Throughput is one request per 4 cycles.
- Register x0 always returns 0, regardless of register-file data or bypass.
- A non-granted requester must hold its request; the block does not queue.

Optional Feature:
- Macro RF_ARB_BYPASS_EN.
- Defined: during ISSUE, if from_rob=1, from_rob_rd!=0 and from_rob_rd equals a requested operand's register, latch from_rob_wdata for that operand. In WAIT, this latched value overrides from_rf data. This fixes the stale read caused by a commit on the same edge the register file samples the read.
- Undefined: register-file data is passed unchanged.

Test Plan:
- Single request: req0 rs1=5 (RF x5=0x1234), rs2=6 (0xABCD), tag=2 -> ISSUE one cycle later; resp_valid=01, resp_tag=2, rs1=0x1234, rs2=0xABCD at handshake+3.
- Both requesters valid and held from reset -> grants in order 0,1,0,1; each resp_valid is one-hot for the correct requester; requester not granted sees no req_ready.
- Only rs2 enabled, rs2=0 -> to_rf_rs1_flag=0, resp_rs1=0, resp_rs2=0; request with no enables -> resp_valid at handshake+1, no to_rf flags.
- With RF_ARB_BYPASS_EN, rs1=7 (RF x7=1) and from_rob rd=7 data=99 during ISSUE -> resp_rs1=99. Without the macro -> resp_rs1=1. The same case with rd=0 -> no override.
- rdy_in low for 3 cycles during WAIT -> outputs and state frozen; the response completes 3 cycles late with correct data.
- rst_n_in pulsed low in WAIT -> all outputs 0 immediately; a subsequent from_rf return produces no resp_valid; the next request after reset is granted to req0.

Source files
------------

// File: rtl/rf_read_arbiter_if.sv
// Requester-side bus of rf_read_arbiter: per-requester request fields and the
// shared response returned to the granted requester.
interface rf_read_arbiter_if #(
  parameter int NUM_REQ   = 2,
  parameter int TAG_WIDTH = 2
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0]           req_rs1_en;
  logic [NUM_REQ-1:0]           req_rs2_en;
  logic [NUM_REQ*5-1:0]         req_rs1;
  logic [NUM_REQ*5-1:0]         req_rs2;
  logic [NUM_REQ*TAG_WIDTH-1:0] req_tag;
  logic [NUM_REQ-1:0]           resp_valid;
  logic [TAG_WIDTH-1:0]         resp_tag;
  logic [31:0]                  resp_rs1;
  logic [31:0]                  resp_rs2;

  modport master (
    output req_valid, req_rs1_en, req_rs2_en, req_rs1, req_rs2, req_tag,
    input  req_ready, resp_valid, resp_tag, resp_rs1, resp_rs2
  );

  modport slave (
    input  req_valid, req_rs1_en, req_rs2_en, req_rs1, req_rs2, req_tag,
    output req_ready, resp_valid, resp_tag, resp_rs1, resp_rs2
  );
endinterface

// File: rtl/rf_read_arbiter.sv
// Round-robin arbiter sharing the register-file read channel among NUM_REQ requesters.
// Optional macro RF_ARB_BYPASS_EN patches operands with ROB commits racing the read.
module rf_read_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int TAG_WIDTH = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rdy_in,
  rf_read_arbiter_if.slave     bus,
  output logic                 to_rf_rs1_flag,
  output logic                 to_rf_rs2_flag,
  output logic [4:0]           to_rf_rs1,
  output logic [4:0]           to_rf_rs2,
  output logic [TAG_WIDTH-1:0] to_rf_index,
  input  logic                 from_rf_rs1_flag,
  input  logic                 from_rf_rs2_flag,
  input  logic [TAG_WIDTH-1:0] from_rf_index,
  input  logic [31:0]          from_rf_rs1,
  input  logic [31:0]          from_rf_rs2,
  input  logic                 from_rob,
  input  logic [4:0]           from_rob_rd,
  input  logic [31:0]          from_rob_wdata
);
  localparam int DATA_W = 32;
  localparam int PTR_W  = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                state_q;
  logic [PTR_W-1:0]      rr_ptr_q, gnt_q, gnt_idx, cand;
  logic                  gnt_found, accept;
  logic                  en1_q, en2_q, got1_q, got2_q, flag1_q, flag2_q;
  logic [4:0]            rs1_q, rs2_q, sel_rs1, sel_rs2;
  logic                  sel_en1, sel_en2;
  logic [TAG_WIDTH-1:0]  tag_q, sel_tag;
  logic [DATA_W-1:0]     op1_q, op2_q, rf1_data, rf2_data, val1, val2;
  logic [NUM_REQ-1:0]    resp_vld_q;
  logic                  hit1, hit2, done;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

  // First valid requester at or after the round-robin pointer, with wrap.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = PTR_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_rs1 = '0;
    sel_rs2 = '0;
    sel_en1 = 1'b0;
    sel_en2 = 1'b0;
    sel_tag = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_idx == PTR_W'(k)) begin
        sel_rs1 = bus.req_rs1[5*k +: 5];
        sel_rs2 = bus.req_rs2[5*k +: 5];
        sel_en1 = bus.req_rs1_en[k];
        sel_en2 = bus.req_rs2_en[k];
        sel_tag = bus.req_tag[TAG_WIDTH*k +: TAG_WIDTH];
      end
    end
  end

  assign accept        = rst_n_in && rdy_in && (state_q == IDLE) && gnt_found;
  assign bus.req_ready = accept ? onehot(gnt_idx) : '0;

`ifdef RF_ARB_BYPASS_EN
  logic              byp1_vld_q, byp2_vld_q;
  logic [DATA_W-1:0] byp1_q, byp2_q;

  // A commit seen while the RF samples the read would otherwise return stale data.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      byp1_vld_q <= 1'b0;
      byp2_vld_q <= 1'b0;
      byp1_q     <= '0;
      byp2_q     <= '0;
    end else if (rdy_in) begin
      if (accept) begin
        byp1_vld_q <= 1'b0;
        byp2_vld_q <= 1'b0;
      end else if (state_q == ISSUE && from_rob && from_rob_rd != 5'd0) begin
        if (en1_q && from_rob_rd == rs1_q) begin
          byp1_vld_q <= 1'b1;
          byp1_q     <= from_rob_wdata;
        end
        if (en2_q && from_rob_rd == rs2_q) begin
          byp2_vld_q <= 1'b1;
          byp2_q     <= from_rob_wdata;
        end
      end
    end
  end

  assign rf1_data = byp1_vld_q ? byp1_q : from_rf_rs1;
  assign rf2_data = byp2_vld_q ? byp2_q : from_rf_rs2;
`else
  logic unused_rob;
  assign unused_rob = ^{from_rob, from_rob_rd, from_rob_wdata};
  assign rf1_data   = from_rf_rs1;
  assign rf2_data   = from_rf_rs2;
`endif

  assign val1 = (rs1_q == 5'd0) ? '0 : rf1_data;
  assign val2 = (rs2_q == 5'd0) ? '0 : rf2_data;
  assign hit1 = (state_q == WAIT) && en1_q && !got1_q && from_rf_rs1_flag && (from_rf_index == tag_q);
  assign hit2 = (state_q == WAIT) && en2_q && !got2_q && from_rf_rs2_flag && (from_rf_index == tag_q);
  assign done = (!en1_q || got1_q || hit1) && (!en2_q || got2_q || hit2);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      en1_q      <= 1'b0;
      en2_q      <= 1'b0;
      got1_q     <= 1'b0;
      got2_q     <= 1'b0;
      flag1_q    <= 1'b0;
      flag2_q    <= 1'b0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      tag_q      <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      resp_vld_q <= '0;
    end else if (rdy_in) begin
      case (state_q)
        IDLE: if (accept) begin
          gnt_q    <= gnt_idx;
          rr_ptr_q <= PTR_W'((int'(gnt_idx) + 1) % NUM_REQ);
          en1_q    <= sel_en1;
          en2_q    <= sel_en2;
          rs1_q    <= sel_rs1;
          rs2_q    <= sel_rs2;
          tag_q    <= sel_tag;
          op1_q    <= '0;
          op2_q    <= '0;
          got1_q   <= 1'b0;
          got2_q   <= 1'b0;
          if (sel_en1 || sel_en2) begin
            state_q <= ISSUE;
            flag1_q <= sel_en1;
            flag2_q <= sel_en2;
          end else begin
            state_q    <= RESP;
            resp_vld_q <= onehot(gnt_idx);
          end
        end
        ISSUE: begin
          flag1_q <= 1'b0;
          flag2_q <= 1'b0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (hit1) begin
            op1_q  <= val1;
            got1_q <= 1'b1;
          end
          if (hit2) begin
            op2_q  <= val2;
            got2_q <= 1'b1;
          end
          if (done) begin
            state_q    <= RESP;
            resp_vld_q <= onehot(gnt_q);
          end
        end
        RESP: begin
          resp_vld_q <= '0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign to_rf_rs1_flag = flag1_q;
  assign to_rf_rs2_flag = flag2_q;
  assign to_rf_rs1      = rs1_q;
  assign to_rf_rs2      = rs2_q;
  assign to_rf_index    = tag_q;
  assign bus.resp_valid = resp_vld_q;
  assign bus.resp_tag   = tag_q;
  assign bus.resp_rs1   = op1_q;
  assign bus.resp_rs2   = op2_q;
endmodule

// File: tb/tb_rf_read_arbiter.sv
// Directed bench for rf_read_arbiter: vector table plus round-robin, stall and reset sequences.
module tb_rf_read_arbiter;
  localparam int NUM_REQ   = 2;
  localparam int TAG_WIDTH = 2;
`ifdef RF_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b1;
  always #5 clk = ~clk;

  rf_read_arbiter_if #(.NUM_REQ(NUM_REQ), .TAG_WIDTH(TAG_WIDTH)) bus ();

  logic                 to_rf_rs1_flag, to_rf_rs2_flag;
  logic [4:0]           to_rf_rs1, to_rf_rs2;
  logic [TAG_WIDTH-1:0] to_rf_index;
  logic                 from_rf_rs1_flag, from_rf_rs2_flag;
  logic [TAG_WIDTH-1:0] from_rf_index;
  logic [31:0]          from_rf_rs1, from_rf_rs2;
  logic                 from_rob = 1'b0;
  logic [4:0]           from_rob_rd = 5'd0;
  logic [31:0]          from_rob_wdata = 32'd0;

  rf_read_arbiter #(.NUM_REQ(NUM_REQ), .TAG_WIDTH(TAG_WIDTH)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .bus(bus),
    .to_rf_rs1_flag(to_rf_rs1_flag), .to_rf_rs2_flag(to_rf_rs2_flag),
    .to_rf_rs1(to_rf_rs1), .to_rf_rs2(to_rf_rs2), .to_rf_index(to_rf_index),
    .from_rf_rs1_flag(from_rf_rs1_flag), .from_rf_rs2_flag(from_rf_rs2_flag),
    .from_rf_index(from_rf_index), .from_rf_rs1(from_rf_rs1), .from_rf_rs2(from_rf_rs2),
    .from_rob(from_rob), .from_rob_rd(from_rob_rd), .from_rob_wdata(from_rob_wdata)
  );

  // Register-file model: one-cycle registered read, frozen with the global ready.
  logic [31:0]          rf [32];
  logic                 mdl_f1 = 1'b0, mdl_f2 = 1'b0;
  logic [TAG_WIDTH-1:0] mdl_idx = '0;
  logic [31:0]          mdl_d1 = '0, mdl_d2 = '0;
  logic                 inj = 1'b0, inj_f = 1'b0;
  logic [TAG_WIDTH-1:0] inj_idx = '0;
  logic [31:0]          inj_d = '0;

  always @(posedge clk) begin
    if (rdy) begin
      mdl_f1  <= to_rf_rs1_flag;
      mdl_f2  <= to_rf_rs2_flag;
      mdl_idx <= to_rf_index;
      mdl_d1  <= rf[to_rf_rs1];
      mdl_d2  <= rf[to_rf_rs2];
    end
  end

  assign from_rf_rs1_flag = inj ? inj_f : mdl_f1;
  assign from_rf_rs2_flag = inj ? inj_f : mdl_f2;
  assign from_rf_index    = inj ? inj_idx : mdl_idx;
  assign from_rf_rs1      = inj ? inj_d : mdl_d1;
  assign from_rf_rs2      = inj ? inj_d : mdl_d2;

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    int          r;
    bit          e1, e2;
    logic [4:0]  s1, s2;
    logic [1:0]  t;
    bit          rob;
    logic [4:0]  rrd;
    logic [31:0] rdat;
    logic [31:0] x1, x2;
    int          lat;
  } vec_t;

  vec_t vt[8];

  task automatic set_req(input int r, input bit e1, input bit e2,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [1:0] t);
    bus.req_rs1_en[r] = e1;
    bus.req_rs2_en[r] = e2;
    bus.req_rs1[r*5 +: 5] = s1;
    bus.req_rs2[r*5 +: 5] = s2;
    bus.req_tag[r*TAG_WIDTH +: TAG_WIDTH] = t;
  endtask

  // Caller is at a negedge; returns at the negedge of the response cycle.
  task automatic run_txn(input int id, input vec_t v);
    bit seen;
    int w;
    set_req(v.r, v.e1, v.e2, v.s1, v.s2, v.t);
    bus.req_valid[v.r] = 1'b1;
    #1;
    w = 0;
    while (bus.req_ready[v.r] !== 1'b1 && w < 20) begin
      @(negedge clk); #1; w++;
    end
    chk($sformatf("v%0d_grant", id), 32'(bus.req_ready), 32'(2'b01 << v.r));
    if (bus.req_ready[v.r] !== 1'b1) begin
      bus.req_valid = '0;
      return;
    end
    @(posedge clk); #1;
    bus.req_valid[v.r] = 1'b0;
    seen = 1'b0;
    for (int c = 1; c <= 10 && !seen; c++) begin
      @(negedge clk);
      if (c == 1 && v.lat == 3) begin
        chk($sformatf("v%0d_iss_flags", id), 32'({to_rf_rs1_flag, to_rf_rs2_flag}), 32'({v.e1, v.e2}));
        chk($sformatf("v%0d_iss_regs", id), 32'({to_rf_rs1, to_rf_rs2}), 32'({v.s1, v.s2}));
        chk($sformatf("v%0d_iss_index", id), 32'(to_rf_index), 32'(v.t));
      end
      if (bus.resp_valid != '0) begin
        seen = 1'b1;
        chk($sformatf("v%0d_latency", id), 32'(c), 32'(v.lat));
        chk($sformatf("v%0d_resp_valid", id), 32'(bus.resp_valid), 32'(2'b01 << v.r));
        chk($sformatf("v%0d_resp_tag", id), 32'(bus.resp_tag), 32'(v.t));
        chk($sformatf("v%0d_resp_rs1", id), bus.resp_rs1, v.x1);
        chk($sformatf("v%0d_resp_rs2", id), bus.resp_rs2, v.x2);
        chk($sformatf("v%0d_rf_flags_idle", id), 32'({to_rf_rs1_flag, to_rf_rs2_flag}), 32'd0);
      end
      if (c == 1 && v.rob) begin
        from_rob = 1'b1; from_rob_rd = v.rrd; from_rob_wdata = v.rdat;
      end
      if (c == 2) from_rob = 1'b0;
    end
    from_rob = 1'b0;
    if (!seen) chk($sformatf("v%0d_resp_seen", id), 32'(seen), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int exp_g;
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
    rf[0] = 32'hDEAD_BEEF;
    rf[5] = 32'h0000_1234;
    rf[6] = 32'h0000_ABCD;
    rf[7] = 32'h0000_0001;

    vt[0] = '{0, 1'b1, 1'b1, 5'd5, 5'd6, 2'd2, 1'b0, 5'd0, 32'd0, 32'h1234, 32'hABCD, 3};
    vt[1] = '{1, 1'b1, 1'b1, 5'd7, 5'd5, 2'd1, 1'b0, 5'd0, 32'd0, 32'h1, 32'h1234, 3};
    vt[2] = '{0, 1'b0, 1'b1, 5'd9, 5'd0, 2'd3, 1'b0, 5'd0, 32'd0, 32'h0, 32'h0, 3};
    vt[3] = '{1, 1'b0, 1'b0, 5'd5, 5'd6, 2'd2, 1'b0, 5'd0, 32'd0, 32'h0, 32'h0, 1};
    vt[4] = '{0, 1'b1, 1'b0, 5'd0, 5'd6, 2'd1, 1'b0, 5'd0, 32'd0, 32'h0, 32'h0, 3};
    vt[5] = '{1, 1'b1, 1'b1, 5'd7, 5'd8, 2'd3, 1'b1, 5'd7, 32'd99, (BYP ? 32'd99 : 32'd1), 32'h1008, 3};
    vt[6] = '{0, 1'b1, 1'b1, 5'd7, 5'd8, 2'd0, 1'b1, 5'd0, 32'd99, 32'd1, 32'h1008, 3};
    vt[7] = '{1, 1'b1, 1'b1, 5'd7, 5'd8, 2'd2, 1'b1, 5'd8, 32'd77, 32'd1, (BYP ? 32'd77 : 32'h1008), 3};

    bus.req_valid = '0; bus.req_rs1_en = '0; bus.req_rs2_en = '0;
    bus.req_rs1 = '0; bus.req_rs2 = '0; bus.req_tag = '0;

    // Reset state, with requests pending that must not be granted.
    bus.req_valid = 2'b11;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_rf_flags", 32'({to_rf_rs1_flag, to_rf_rs2_flag}), 32'd0);
    chk("rst_resp_data", bus.resp_rs1 | bus.resp_rs2, 32'd0);
    bus.req_valid = '0;
    rst_n = 1'b1;
    @(negedge clk);

    // Round robin with both requesters held valid.
    set_req(0, 1'b1, 1'b0, 5'd5, 5'd0, 2'd0);
    set_req(1, 1'b1, 1'b0, 5'd6, 5'd0, 2'd1);
    bus.req_valid = 2'b11;
    #1;
    exp_g = 0;
    for (int g = 0; g < 4; g++) begin
      w = 0;
      while (bus.req_ready == '0 && w < 20) begin @(negedge clk); #1; w++; end
      chk($sformatf("rr%0d_grant", g), 32'(bus.req_ready), 32'(2'b01 << exp_g));
      w = 0;
      do begin @(negedge clk); #1; w++; end while (bus.resp_valid == '0 && w < 20);
      chk($sformatf("rr%0d_resp_valid", g), 32'(bus.resp_valid), 32'(2'b01 << exp_g));
      chk($sformatf("rr%0d_resp_rs1", g), bus.resp_rs1, (exp_g == 0) ? 32'h1234 : 32'hABCD);
      exp_g = 1 - exp_g;
    end
    bus.req_valid = '0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_txn(i, vt[i]);
    @(negedge clk);

    // Global ready low for three cycles while waiting on the register file.
    set_req(1, 1'b1, 1'b1, 5'd7, 5'd6, 2'd2);
    bus.req_valid = 2'b10;
    #1;
    chk("stall_grant", 32'(bus.req_ready), 32'b10);
    @(posedge clk); #1;
    bus.req_valid = '0;
    begin
      bit seen = 1'b0;
      for (int c = 1; c <= 12 && !seen; c++) begin
        @(negedge clk);
        if (c >= 3 && c <= 5) begin
          #1;
          chk($sformatf("stall%0d_resp_valid", c), 32'(bus.resp_valid), 32'd0);
          chk($sformatf("stall%0d_req_ready", c), 32'(bus.req_ready), 32'd0);
          chk($sformatf("stall%0d_resp_tag", c), 32'(bus.resp_tag), 32'd2);
        end
        if (bus.resp_valid != '0) begin
          seen = 1'b1;
          chk("stall_latency", 32'(c), 32'd6);
          chk("stall_resp_valid", 32'(bus.resp_valid), 32'b10);
          chk("stall_resp_rs1", bus.resp_rs1, 32'h1);
          chk("stall_resp_rs2", bus.resp_rs2, 32'hABCD);
        end
        if (c == 2) begin rdy = 1'b0; bus.req_valid = 2'b01; end
        if (c == 5) begin bus.req_valid = '0; rdy = 1'b1; end
      end
      if (!seen) chk("stall_resp_seen", 32'(seen), 32'd1);
    end
    @(negedge clk);

    // Reset in WAIT abandons the transaction and returns the pointer to 0.
    set_req(0, 1'b1, 1'b1, 5'd5, 5'd6, 2'd3);
    bus.req_valid = 2'b01;
    #1;
    chk("rstw_grant", 32'(bus.req_ready), 32'b01);
    @(posedge clk); #1;
    bus.req_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstw_to_rf_rs1", 32'(to_rf_rs1), 32'd0);
    chk("rstw_to_rf_index", 32'(to_rf_index), 32'd0);
    chk("rstw_resp_tag", 32'(bus.resp_tag), 32'd0);
    chk("rstw_resp_valid", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    inj = 1'b1; inj_f = 1'b1; inj_idx = 2'd3; inj_d = 32'h5555_5555;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rstw_late%0d_resp_valid", c), 32'(bus.resp_valid), 32'd0);
    end
    inj = 1'b0;
    set_req(0, 1'b0, 1'b0, 5'd0, 5'd0, 2'd0);
    set_req(1, 1'b0, 1'b0, 5'd0, 5'd0, 2'd1);
    bus.req_valid = 2'b11;
    #1;
    chk("rstw_next_grant", 32'(bus.req_ready), 32'b01);
    bus.req_valid = '0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
